// File: rtl/mips_mem_responder.sv
// Word-addressed program/data store for pipe_MIPS32 with a fetch port and a load/store port.
// One transaction in flight at a time. Defining MEM_INIT_CLR_EN adds a zeroing sweep after reset.
module mips_mem_responder #(
  parameter int          ADDR_W     = 10,
  parameter int          DEPTH      = 1024,
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] HLT_WORD   = 32'hFC00_0000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              busy,
  output logic              addr_err
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(RD_LATENCY) + 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INIT} state_t;

`ifdef MEM_INIT_CLR_EN
  localparam state_t RST_STATE = S_INIT;
  logic [ADDR_W-1:0] init_ptr;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic              owner_d;
  logic [31:0]       rd_q;
  logic [CNT_W-1:0]  cnt;
  logic              acc_d, acc_if, acc;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_in_range;
  logic [31:0]       acc_data;

  // Data port wins ties; the fetch initiator simply holds its request.
  assign acc_d        = rst_n && d_req_valid && d_req_ready;
  assign acc_if       = rst_n && if_req_valid && if_req_ready;
  assign acc          = acc_d || acc_if;
  assign acc_addr     = acc_d ? d_req_addr : if_req_addr;
  assign acc_in_range = {1'b0, acc_addr} < DEPTH_L;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    acc_data = '0;
    if (!(acc_d && d_req_we))
      acc_data = acc_in_range ? mem[acc_addr[IDX_W-1:0]] : HLT_WORD;
  end

  // The response is registered on the edge that returns to IDLE, so "IDLE" already
  // covers the response cycle and a new request can be taken while the pulse is out.
  always_comb begin
    state_nxt    = state;
    d_req_ready  = (state == S_IDLE);
    if_req_ready = (state == S_IDLE) && !d_req_valid;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: if (acc && RD_LATENCY > 1) state_nxt = S_WAIT;
      S_WAIT: if (cnt == CNT_LAST) state_nxt = S_IDLE;
`ifdef MEM_INIT_CLR_EN
      S_INIT: if (init_ptr == ADDR_W'(DEPTH - 1)) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential logic uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      addr_err     <= 1'b0;
      owner_d      <= 1'b0;
      rd_q         <= '0;
      cnt          <= '0;
`ifdef MEM_INIT_CLR_EN
      init_ptr     <= '0;
`endif
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if (acc) begin
        if (!acc_in_range) addr_err <= 1'b1;
        if (RD_LATENCY == 1) begin
          if (acc_d) begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= acc_data;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= acc_data;
          end
        end else begin
          owner_d <= acc_d;
          rd_q    <= acc_data;
          cnt     <= '0;
        end
      end else if (state == S_WAIT) begin
        if (cnt == CNT_LAST) begin
          if (owner_d) begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= rd_q;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= rd_q;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
`ifdef MEM_INIT_CLR_EN
      if (state == S_INIT) init_ptr <= init_ptr + 1'b1;
`endif
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and change only by stores or the INIT sweep.
  always_ff @(posedge clk1) begin
    if (acc_d && d_req_we && acc_in_range) mem[acc_addr[IDX_W-1:0]] <= d_req_wdata;
`ifdef MEM_INIT_CLR_EN
    if (rst_n && state == S_INIT) mem[init_ptr[IDX_W-1:0]] <= '0;
`endif
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench for mips_mem_responder against a plain array model of the store.
// Main instance: DEPTH=512, RD_LATENCY=2; second instance: RD_LATENCY=1; third (MEM_INIT_CLR_EN only): DEPTH=16.
module tb_mips_mem_responder;
  localparam int          AW    = 10;
  localparam int          DEPTH = 512;
  localparam logic [31:0] HLT   = 32'hFC00_0000;
`ifdef MEM_INIT_CLR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic          rst_n;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [31:0]   if_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [AW-1:0] d_req_addr;
  logic [31:0]   d_req_wdata, d_rsp_data;
  logic          busy, addr_err;

  logic          b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
  logic [AW-1:0] b_if_req_addr;
  logic [31:0]   b_if_rsp_data;
  logic          b_d_req_valid, b_d_req_ready, b_d_req_we, b_d_rsp_valid;
  logic [AW-1:0] b_d_req_addr;
  logic [31:0]   b_d_req_wdata, b_d_rsp_data;
  logic          b_busy, b_addr_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem  [DEPTH];
  logic [31:0] model_mem2 [DEPTH];
  bit          model_err;

  mips_mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .RD_LATENCY(2), .HLT_WORD(HLT)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .busy(busy), .addr_err(addr_err));

  mips_mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .RD_LATENCY(1), .HLT_WORD(HLT)) dut2 (
    .clk1(clk1), .rst_n(rst_n),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_addr(b_if_req_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_req_we(b_d_req_we),
    .d_req_addr(b_d_req_addr), .d_req_wdata(b_d_req_wdata),
    .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
    .busy(b_busy), .addr_err(b_addr_err));

`ifdef MEM_INIT_CLR_EN
  logic        rst3_n;
  logic        c_if_req_valid, c_if_req_ready, c_if_rsp_valid;
  logic [3:0]  c_if_req_addr;
  logic [31:0] c_if_rsp_data;
  logic        c_d_req_valid, c_d_req_ready, c_d_req_we, c_d_rsp_valid;
  logic [3:0]  c_d_req_addr;
  logic [31:0] c_d_req_wdata, c_d_rsp_data;
  logic        c_busy, c_addr_err;

  mips_mem_responder #(.ADDR_W(4), .DEPTH(16), .RD_LATENCY(2), .HLT_WORD(HLT)) dut3 (
    .clk1(clk1), .rst_n(rst3_n),
    .if_req_valid(c_if_req_valid), .if_req_ready(c_if_req_ready), .if_req_addr(c_if_req_addr),
    .if_rsp_valid(c_if_rsp_valid), .if_rsp_data(c_if_rsp_data),
    .d_req_valid(c_d_req_valid), .d_req_ready(c_d_req_ready), .d_req_we(c_d_req_we),
    .d_req_addr(c_d_req_addr), .d_req_wdata(c_d_req_wdata),
    .d_rsp_valid(c_d_rsp_valid), .d_rsp_data(c_d_rsp_data),
    .busy(c_busy), .addr_err(c_addr_err));
`endif

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_read(input int addr);
    return (addr < DEPTH) ? model_mem[addr] : HLT;
  endfunction

  // One request on the main instance; reports first-pulse latency (-1 if none) and
  // whether the other port pulsed or the pulse lasted more than one cycle.
  task automatic xact(input bit is_d, input bit we, input int addr, input logic [31:0] wd,
                      output logic [31:0] rdata, output int lat, output bit stray);
    bit got;
    got = 1'b0; lat = -1; rdata = 'x; stray = 1'b0;
    @(negedge clk1);
    if (is_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr[AW-1:0]; d_req_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr[AW-1:0];
    end
    for (int n = 0; n < 20 && !(is_d ? d_req_ready : if_req_ready); n++) @(negedge clk1);
    @(posedge clk1); #1;
    d_req_valid = 1'b0; if_req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk1);
      if (is_d ? if_rsp_valid : d_rsp_valid) stray = 1'b1;
      if (is_d ? d_rsp_valid : if_rsp_valid) begin
        if (!got) begin
          got = 1'b1; lat = n; rdata = is_d ? d_rsp_data : if_rsp_data;
        end else stray = 1'b1;
      end
      if (got && n >= lat + 1) break;
    end
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    model_err = 1'b0;
    if (INIT_EN) begin
      int n;
      for (n = 0; n < 1200 && (busy || b_busy); n++) @(negedge clk1);
      checks++;
      if (busy || b_busy) begin
        failures++; $display("FAIL init_sweep_end: busy=%0b b_busy=%0b after %0d clocks", busy, b_busy, n);
      end
      for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_mem2[i] = '0; end
    end
    @(negedge clk1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk1);
    checks++;
    if ({if_rsp_valid, d_rsp_valid, addr_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: if_rsp_valid/d_rsp_valid/addr_err=%b want 000", {if_rsp_valid, d_rsp_valid, addr_err});
    end
    checks++;
    if ({if_rsp_data, d_rsp_data} !== 64'h0) begin
      failures++; $display("FAIL reset_data: if=%h d=%h want 0", if_rsp_data, d_rsp_data);
    end
    checks++;
    if ({busy, d_req_ready, if_req_ready} !== {INIT_EN, !INIT_EN, !INIT_EN}) begin
      failures++; $display("FAIL reset_ready_busy: busy/d_ready/if_ready=%b want %b", {busy, d_req_ready, if_req_ready}, {INIT_EN, !INIT_EN, !INIT_EN});
    end
    reset_release();
  endtask

  task automatic test_fetch();
    logic [31:0] rd; int lat; bit stray; int a;
    @(negedge clk1);
    dut.mem[5] <= 32'h2001_000A;
    model_mem[5] = 32'h2001_000A;
    xact(1'b0, 1'b0, 5, '0, rd, lat, stray);
    checks++;
    if (rd !== 32'h2001_000A || lat !== 2 || stray) begin
      failures++; $display("FAIL fetch_addr5: data=%h lat=%0d stray=%0b want 2001000a lat=2 stray=0", rd, lat, stray);
    end
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      xact(1'b0, 1'b0, a, '0, rd, lat, stray);
      checks++;
      if (rd !== ref_read(a) || lat !== 2 || stray) begin
        failures++; $display("FAIL fetch_rand addr=%0d: data=%h lat=%0d stray=%0b want %h lat=2", a, rd, lat, stray, ref_read(a));
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; int lat; bit stray;
    xact(1'b1, 1'b1, 20, 32'hDEAD_BEEF, rd, lat, stray);
    model_mem[20] = 32'hDEAD_BEEF;
    checks++;
    if (rd !== 32'h0 || lat !== 2 || stray) begin
      failures++; $display("FAIL store_ack: data=%h lat=%0d stray=%0b want 0 lat=2", rd, lat, stray);
    end
    xact(1'b1, 1'b0, 20, '0, rd, lat, stray);
    checks++;
    if (rd !== 32'hDEAD_BEEF || lat !== 2 || stray) begin
      failures++; $display("FAIL load_after_store: data=%h lat=%0d stray=%0b want deadbeef lat=2", rd, lat, stray);
    end
  endtask

  task automatic test_arbitration();
    int d_cnt, i_cnt, d_at, i_at; logic [31:0] d_dat, i_dat; bit pend;
    d_cnt = 0; i_cnt = 0; d_at = -1; i_at = -1; d_dat = 'x; i_dat = 'x;
    @(negedge clk1);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'd100;
    if_req_valid = 1'b1; if_req_addr = 10'd101;
    #1;
    checks++;
    if ({d_req_ready, if_req_ready} !== 2'b10) begin
      failures++; $display("FAIL arb_ready: d/if ready=%b want 10", {d_req_ready, if_req_ready});
    end
    @(posedge clk1); #1;
    d_req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk1);
      if (d_rsp_valid) begin d_cnt++; d_at = n; d_dat = d_rsp_data; end
      if (if_rsp_valid) begin i_cnt++; i_at = n; i_dat = if_rsp_data; end
      pend = if_req_valid && if_req_ready;
      @(posedge clk1); #1;
      if (pend) if_req_valid = 1'b0;
    end
    checks++;
    if (d_cnt !== 1 || d_at !== 2 || d_dat !== ref_read(100)) begin
      failures++; $display("FAIL arb_data_first: pulses=%0d at=%0d data=%h want 1 at 2 data %h", d_cnt, d_at, d_dat, ref_read(100));
    end
    checks++;
    if (i_cnt !== 1 || i_at !== 4 || i_dat !== ref_read(101)) begin
      failures++; $display("FAIL arb_fetch_next: pulses=%0d at=%0d data=%h want 1 at 4 data %h", i_cnt, i_at, i_dat, ref_read(101));
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; bit stray;
    checks++;
    if (addr_err !== 1'b0) begin
      failures++; $display("FAIL oor_err_clear: addr_err=%b want 0", addr_err);
    end
    xact(1'b0, 1'b0, 1023, '0, rd, lat, stray);
    checks++;
    if (rd !== HLT || lat !== 2 || stray) begin
      failures++; $display("FAIL oor_fetch: data=%h lat=%0d want fc000000 lat=2", rd, lat);
    end
    checks++;
    if (addr_err !== 1'b1) begin
      failures++; $display("FAIL oor_err_set: addr_err=%b want 1", addr_err);
    end
    xact(1'b1, 1'b1, 700, 32'h1234_5678, rd, lat, stray);
    checks++;
    if (rd !== 32'h0 || lat !== 2) begin
      failures++; $display("FAIL oor_store_ack: data=%h lat=%0d want 0 lat=2", rd, lat);
    end
    xact(1'b1, 1'b0, 3, '0, rd, lat, stray);
    checks++;
    if (rd !== ref_read(3) || addr_err !== 1'b1) begin
      failures++; $display("FAIL oor_sticky: data=%h addr_err=%b want %h addr_err=1", rd, addr_err, ref_read(3));
    end
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    checks++;
    if (addr_err !== 1'b0) begin
      failures++; $display("FAIL oor_err_reset: addr_err=%b want 0", addr_err);
    end
    reset_release();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; bit stray; int pulses;
    pulses = 0;
    @(negedge clk1);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'd30; d_req_wdata = 32'hCAFE_0030;
    @(posedge clk1); #1;
    d_req_valid = 1'b0; rst_n = 1'b0;
    model_mem[30] = 32'hCAFE_0030;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk1);
      if (d_rsp_valid || if_rsp_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL reset_mid_no_pulse: pulses=%0d want 0", pulses);
    end
    reset_release();
    xact(1'b1, 1'b0, 30, '0, rd, lat, stray);
    checks++;
    if (rd !== ref_read(30) || lat !== 2) begin
      failures++; $display("FAIL reset_mid_store_kept: data=%h lat=%0d want %h", rd, lat, ref_read(30));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, wd; int lat; bit stray, is_d, we; int a;
    for (int k = 0; k < 30; k++) begin
      is_d = $urandom_range(0, 1);
      we   = is_d && ($urandom_range(0, 2) == 0);
      a    = $urandom_range(0, 639);
      wd   = $urandom;
      exp  = we ? 32'h0 : ref_read(a);
      xact(is_d, we, a, wd, rd, lat, stray);
      if (we && a < DEPTH) model_mem[a] = wd;
      if (a >= DEPTH) model_err = 1'b1;
      checks++;
      if (rd !== exp || lat !== 2 || stray || addr_err !== model_err) begin
        failures++;
        $display("FAIL random k=%0d d=%0b we=%0b addr=%0d: data=%h lat=%0d stray=%0b err=%b want %h lat=2 err=%b",
                 k, is_d, we, a, rd, lat, stray, addr_err, exp, model_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a [8]; int pulses, drops, bad; logic [31:0] exp;
    pulses = 0; drops = 0; bad = 0;
    for (int k = 0; k < 8; k++) a[k] = (k == 5) ? 777 : $urandom_range(0, DEPTH - 1);
    @(negedge clk1);
    b_d_req_valid = 1'b1; b_d_req_we = 1'b0; b_d_req_addr = a[0][AW-1:0];
    for (int k = 0; k < 8; k++) begin
      if (!b_d_req_ready) drops++;
      @(posedge clk1); #1;
      if (k < 7) b_d_req_addr = a[k+1][AW-1:0];
      else       b_d_req_valid = 1'b0;
      @(negedge clk1);
      exp = (a[k] < DEPTH) ? model_mem2[a[k]] : HLT;
      if (b_d_rsp_valid) pulses++;
      if (b_d_rsp_valid !== 1'b1 || b_d_rsp_data !== exp || b_if_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL b2b_data k=%0d addr=%0d: valid=%b data=%h want 1 %h", k, a[k], b_d_rsp_valid, b_d_rsp_data, exp);
      end
    end
    checks++;
    if (bad !== 0 || pulses !== 8) begin
      failures++; $display("FAIL b2b_pulses: pulses=%0d bad=%0d want 8 and 0", pulses, bad);
    end
    checks++;
    if (drops !== 0) begin
      failures++; $display("FAIL b2b_ready: ready low %0d times want 0", drops);
    end
    @(negedge clk1);
    checks++;
    if (b_d_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_end: d_rsp_valid=%b want 0", b_d_rsp_valid);
    end
  endtask

`ifdef MEM_INIT_CLR_EN
  task automatic test_init();
    int cnt, pulses, a; logic [31:0] rd;
    cnt = 0; pulses = 0; rd = 'x;
    repeat (2) @(negedge clk1);
    rst3_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (c_d_req_ready) break;
      cnt++;
      @(negedge clk1);
    end
    checks++;
    if (cnt !== 16) begin
      failures++; $display("FAIL init_ready_low: %0d clocks want 16", cnt);
    end
    a = $urandom_range(0, 15);
    c_d_req_valid = 1'b1; c_d_req_we = 1'b0; c_d_req_addr = a[3:0];
    @(posedge clk1); #1;
    c_d_req_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk1);
      if (c_d_rsp_valid) begin pulses++; rd = c_d_rsp_data; end
    end
    checks++;
    if (pulses !== 1 || rd !== 32'h0) begin
      failures++; $display("FAIL init_zeroed addr=%0d: pulses=%0d data=%h want 1 and 0", a, pulses, rd);
    end
    pulses = 0;
    c_d_req_valid = 1'b1; c_d_req_addr = 4'd7;
    @(posedge clk1); #1;
    c_d_req_valid = 1'b0; rst3_n = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk1);
      if (c_d_rsp_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL init_reset_mid: pulses=%0d want 0", pulses);
    end
    rst3_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    b_if_req_valid = 1'b0; b_if_req_addr = '0;
    b_d_req_valid = 1'b0; b_d_req_we = 1'b0; b_d_req_addr = '0; b_d_req_wdata = '0;
    model_err = 1'b0;
`ifdef MEM_INIT_CLR_EN
    rst3_n = 1'b0;
    c_if_req_valid = 1'b0; c_if_req_addr = '0;
    c_d_req_valid = 1'b0; c_d_req_we = 1'b0; c_d_req_addr = '0; c_d_req_wdata = '0;
    for (int i = 0; i < 16; i++) dut3.mem[i] <= 32'hA5A5_0000 | i;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]  = $urandom;
      model_mem2[i] = $urandom;
      dut.mem[i]  <= model_mem[i];
      dut2.mem[i] <= model_mem2[i];
    end
    test_reset();
    test_fetch();
    test_store_load();
    test_arbitration();
    test_out_of_range();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef MEM_INIT_CLR_EN
    test_init();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
